// File: rtl/sp_ram_banked_ctrl.sv
// sp_ram_banked_ctrl: banked single-port RAM (BANKS x LANES byte-maskable macros) with a req/gnt/rvalid port, zero-fill sweep and per-bank idle sleep.
// Optional macro SP_RAM_INIT_EN enables the post-reset zero-fill sweep; undefined starts in RUN with undefined contents.
module sp_ram_banked_ctrl #(
    parameter int RAM_SIZE    = 32768,
    parameter int DATA_WIDTH  = 32,
    parameter int MACRO_WIDTH = 8,
    parameter int MACRO_DEPTH = 2048,
    parameter int IDLE_CYCLES = 16,
    parameter int ADDR_WIDTH  = $clog2(RAM_SIZE),
    localparam int LANES      = DATA_WIDTH / MACRO_WIDTH,
    localparam int BANKS      = RAM_SIZE * 8 / (MACRO_DEPTH * DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    input  logic                    bypass_en_i,
    output logic                    init_done_o,
    output logic [BANKS-1:0]        sleep_o
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LBYTES = MACRO_WIDTH / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int ROW_W  = $clog2(MACRO_DEPTH);
    localparam int BANK_W = BANKS > 1 ? $clog2(BANKS) : 1;
    localparam int CNT_W  = $clog2(IDLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

    typedef enum logic {S_INIT, S_RUN} state_e;
`ifdef SP_RAM_INIT_EN
    localparam state_e RST_STATE = S_INIT;
`else
    localparam state_e RST_STATE = S_RUN;
`endif

    state_e                         state_q, state_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic                           init_done_q;
    logic [BANKS-1:0]               sleep_q, sleep_d;
    logic [BANKS-1:0][CNT_W-1:0]    idle_q, idle_d;
    logic                           rvalid_q, rd_q, byp_q;
    logic [BANK_W-1:0]              bank, bank_q;
    logic [DATA_WIDTH-1:0]          wdata_q;
    logic [BANKS-1:0][DATA_WIDTH-1:0] bank_rd;
    logic [ROW_W-1:0]               row;
    logic                           init_w;

    assign init_w = state_q == S_INIT;
    assign row    = addr_i[OFF_W +: ROW_W];

    if (BANKS > 1) begin : g_bank_dec
        assign bank = addr_i[OFF_W+ROW_W +: BANK_W];
    end else begin : g_one_bank
        assign bank = '0;
    end

    if (OFF_W > 0) begin : g_off
        logic unused_off;
        assign unused_off = ^addr_i[OFF_W-1:0];
    end

    assign gnt_o       = !init_w && req_i && !sleep_q[bank];
    assign rvalid_o    = rvalid_q;
    assign init_done_o = init_done_q;
    assign sleep_o     = sleep_q;
    assign rdata_o     = (rvalid_q && rd_q) ? (byp_q ? wdata_q : bank_rd[bank_q]) : '0;

    // Any request to a bank restarts its idle count: a grant if awake, a wake-up if asleep.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        idle_d  = idle_q;
        sleep_d = sleep_q;
        if (init_w) begin
            row_d   = row_q + 1'b1;
            state_d = (row_q == '1) ? S_RUN : S_INIT;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                idle_d[b]  = (req_i && bank == BANK_W'(b)) ? '0 :
                             (idle_q[b] == IDLE_MAX) ? idle_q[b] : idle_q[b] + 1'b1;
                sleep_d[b] = IDLE_CYCLES != 0 && idle_d[b] == IDLE_MAX;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= RST_STATE;
            row_q       <= '0;
            init_done_q <= RST_STATE == S_RUN;
            sleep_q     <= '0;
            idle_q      <= '0;
            rvalid_q    <= 1'b0;
            rd_q        <= 1'b0;
            byp_q       <= 1'b0;
            bank_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            init_done_q <= state_d == S_RUN;
            sleep_q     <= sleep_d;
            idle_q      <= idle_d;
            rvalid_q    <= gnt_o;
            if (gnt_o) begin
                rd_q    <= !we_i;
                byp_q   <= bypass_en_i;
                bank_q  <= bank;
                wdata_q <= wdata_i;
            end
        end
    end

    // Behavioural macros: active-low select, synchronous byte-masked write, registered read.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [MACRO_WIDTH-1:0] mem [MACRO_DEPTH];
            logic [MACRO_WIDTH-1:0] q;
            logic [MACRO_WIDTH-1:0] d;
            logic [LBYTES-1:0]      mask;
            logic [ROW_W-1:0]       a;
            logic                   cs_n, we;
            assign mask = init_w ? '1 : be_i[l*LBYTES +: LBYTES];
            assign we   = init_w || we_i;
            assign a    = init_w ? row_q : row;
            assign d    = init_w ? '0 : wdata_i[l*MACRO_WIDTH +: MACRO_WIDTH];
            assign cs_n = !(init_w || (gnt_o && bank == BANK_W'(b) &&
                          (!we_i || (|mask && !bypass_en_i))));
            always_ff @(posedge clk) begin
                if (!cs_n && we) begin
                    for (int k = 0; k < LBYTES; k++)
                        if (mask[k]) mem[a][k*8 +: 8] <= d[k*8 +: 8];
                end else if (!cs_n) begin
                    q <= mem[a];
                end
            end
            assign bank_rd[b][l*MACRO_WIDTH +: MACRO_WIDTH] = q;
        end
    end
endmodule

// File: tb/tb_sp_ram_banked_ctrl.sv
// tb_sp_ram_banked_ctrl: directed self-checking bench for sp_ram_banked_ctrl at default parameters.
// Init-sweep checks apply when SP_RAM_INIT_EN is defined.
module tb_sp_ram_banked_ctrl;
    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [14:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        bypass_en_i = 1'b0;
    logic        init_done_o;
    logic [3:0]  sleep_o;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SP_RAM_INIT_EN
    localparam logic EXP_DONE = 1'b0;
`else
    localparam logic EXP_DONE = 1'b1;
`endif

    sp_ram_banked_ctrl dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .bypass_en_i (bypass_en_i),
        .init_done_o (init_done_o),
        .sleep_o     (sleep_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Holds a request until granted (bounded), then returns inside the response cycle.
    task automatic do_req(input logic [14:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
        int waits = 0;
        req_i = 1'b1; addr_i = a; we_i = w; be_i = be; wdata_i = d;
        #1;
        while (gnt_o !== 1'b1 && waits < 40) begin
            @(negedge clk); #1; waits++;
        end
        n_cmp++;
        if (gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL grant_wait addr=%h: gnt_o=%b, required 1", a, gnt_o);
        end
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0;
        #1;
    endtask

    task automatic run_init();
`ifdef SP_RAM_INIT_EN
        int bad = 0;
        req_i = 1'b1; addr_i = '0; we_i = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            #1;
            if (gnt_o !== 1'b0 || init_done_o !== 1'b0) bad++;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL init_stall: %0d sweep cycles had gnt/init_done set, required 0", bad);
        end
        n_cmp++;
        if (init_done_o !== 1'b1 || gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL init_done: init_done_o=%b gnt_o=%b at cycle 2049, required 1 1", init_done_o, gnt_o);
        end
        req_i = 1'b0;
`else
        req_i = 1'b1; addr_i = '0; we_i = 1'b0;
        #1;
        n_cmp++;
        if (init_done_o !== 1'b1 || gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL run_after_reset: init_done_o=%b gnt_o=%b, required 1 1", init_done_o, gnt_o);
        end
        req_i = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({gnt_o, rvalid_o, sleep_o, init_done_o} !== {2'b00, 4'h0, EXP_DONE}) begin
            n_bad++; $display("FAIL reset_ctrl: gnt=%b rvalid=%b sleep=%h done=%b, required 0 0 0 %b",
                              gnt_o, rvalid_o, sleep_o, init_done_o, EXP_DONE);
        end
        n_cmp++;
        if (rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: rdata_o=%h, required 00000000", rdata_o);
        end
        @(negedge clk);
        rstn_i = 1'b1;
        run_init();
    endtask

    task automatic test_init_read();
`ifdef SP_RAM_INIT_EN
        do_req(15'h1004, 1'b0, 4'hF, 32'h0);
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL init_zero: rvalid=%b rdata=%h, required 1 00000000", rvalid_o, rdata_o);
        end
`endif
    endtask

    task automatic test_byte_mask();
        do_req(15'h0000, 1'b1, 4'hF, 32'hDEADBEEF);
        do_req(15'h0000, 1'b1, 4'b0101, 32'h11223344);
        do_req(15'h0000, 1'b0, 4'hF, 32'h0);
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'hDE22BE44) begin
            n_bad++; $display("FAIL byte_mask: rvalid=%b rdata=%h, required 1 DE22BE44", rvalid_o, rdata_o);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL rvalid_single: rvalid=%b rdata=%h, required 0 00000000", rvalid_o, rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        do_req(15'h6000, 1'b1, 4'hF, 32'hAAAA5555);
        do_req(15'h0000, 1'b1, 4'hF, 32'h12345678);
        @(negedge clk);
        req_i = 1'b1; addr_i = 15'h6000; we_i = 1'b0; be_i = 4'hF;
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL b2b_gnt0: gnt_o=%b, required 1", gnt_o);
        end
        @(negedge clk);
        addr_i = 15'h0000;
        #1;
        n_cmp++;
        if (gnt_o !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== 32'hAAAA5555) begin
            n_bad++; $display("FAIL b2b_first: gnt=%b rvalid=%b rdata=%h, required 1 1 AAAA5555", gnt_o, rvalid_o, rdata_o);
        end
        @(negedge clk);
        req_i = 1'b0;
        #1;
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h12345678) begin
            n_bad++; $display("FAIL b2b_second: rvalid=%b rdata=%h, required 1 12345678", rvalid_o, rdata_o);
        end
    endtask

    task automatic test_sleep();
        do_req(15'h4000, 1'b1, 4'hF, 32'h5A5AA5A5);
        repeat (15) @(negedge clk);
        #1;
        n_cmp++;
        if (sleep_o[2] !== 1'b0) begin
            n_bad++; $display("FAIL sleep_early: sleep_o[2]=%b after 15 idle cycles, required 0", sleep_o[2]);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (sleep_o !== 4'hF) begin
            n_bad++; $display("FAIL sleep_all: sleep_o=%h, required F", sleep_o);
        end
        @(negedge clk);
        req_i = 1'b1; addr_i = 15'h4000; we_i = 1'b0; be_i = 4'hF;
        #1;
        n_cmp++;
        if (gnt_o !== 1'b0) begin
            n_bad++; $display("FAIL wake_stall: gnt_o=%b, required 0", gnt_o);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (sleep_o !== 4'hB || gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL wake_gnt: sleep_o=%h gnt_o=%b, required B 1", sleep_o, gnt_o);
        end
        @(negedge clk);
        req_i = 1'b0;
        #1;
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h5A5AA5A5) begin
            n_bad++; $display("FAIL wake_data: rvalid=%b rdata=%h, required 1 5A5AA5A5", rvalid_o, rdata_o);
        end
        @(negedge clk);
        req_i = 1'b1; addr_i = 15'h2000;
        #1;
        n_cmp++;
        if (gnt_o !== 1'b0) begin
            n_bad++; $display("FAIL drop_stall: gnt_o=%b, required 0", gnt_o);
        end
        @(negedge clk);
        req_i = 1'b0;
        #1;
        n_cmp++;
        if (sleep_o !== 4'h9 || rvalid_o !== 1'b0) begin
            n_bad++; $display("FAIL drop_wake: sleep_o=%h rvalid=%b, required 9 0", sleep_o, rvalid_o);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (rvalid_o !== 1'b0) begin
            n_bad++; $display("FAIL drop_no_resp: rvalid=%b, required 0", rvalid_o);
        end
    endtask

    task automatic test_bypass();
        do_req(15'h0010, 1'b1, 4'hF, 32'h0);
        bypass_en_i = 1'b1;
        do_req(15'h0010, 1'b1, 4'hF, 32'hCAFEF00D);
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL bypass_wr_resp: rvalid=%b rdata=%h, required 1 00000000", rvalid_o, rdata_o);
        end
        do_req(15'h0010, 1'b0, 4'hF, 32'h0BADC0DE);
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h0BADC0DE) begin
            n_bad++; $display("FAIL bypass_rd: rvalid=%b rdata=%h, required 1 0BADC0DE", rvalid_o, rdata_o);
        end
        bypass_en_i = 1'b0;
        do_req(15'h0010, 1'b0, 4'hF, 32'h0);
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL bypass_mem: rvalid=%b rdata=%h, required 1 00000000", rvalid_o, rdata_o);
        end
    endtask

    task automatic test_reset_mid();
        do_req(15'h0000, 1'b0, 4'hF, 32'h0);
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h12345678) begin
            n_bad++; $display("FAIL outstanding_rd: rvalid=%b rdata=%h, required 1 12345678", rvalid_o, rdata_o);
        end
        rstn_i = 1'b0;
        #1;
        n_cmp++;
        if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || init_done_o !== EXP_DONE || sleep_o !== 4'h0) begin
            n_bad++; $display("FAIL reset_inflight: rvalid=%b rdata=%h done=%b sleep=%h, required 0 00000000 %b 0",
                              rvalid_o, rdata_o, init_done_o, sleep_o, EXP_DONE);
        end
        @(negedge clk);
        rstn_i = 1'b1;
`ifdef SP_RAM_INIT_EN
        repeat (1000) @(negedge clk);
        req_i = 1'b1; addr_i = 15'h0000;
        #1;
        rstn_i = 1'b0;
        #1;
        n_cmp++;
        if (gnt_o !== 1'b0 || rvalid_o !== 1'b0 || init_done_o !== 1'b0 || rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL reset_row1000: gnt=%b rvalid=%b done=%b rdata=%h, required 0 0 0 00000000",
                              gnt_o, rvalid_o, init_done_o, rdata_o);
        end
        req_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
`endif
        run_init();
`ifdef SP_RAM_INIT_EN
        do_req(15'h0000, 1'b0, 4'hF, 32'h0);
        n_cmp++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL refill: rvalid=%b rdata=%h, required 1 00000000", rvalid_o, rdata_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_byte_mask();
        test_back_to_back();
        test_sleep();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
